// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage feeding decode. Holds the PC, performs a
//            busywait-stalled read handshake with instruction memory, presents
//            one registered instruction at a time, and computes the next PC
//            (sequential, or jump/branch target from a signed word offset).
// Ports    : CLK, RESET           - clock, synchronous active-high reset
//            JUMP, BRANCH, ZERO   - control-flow request for current instr
//            OFFSET               - signed word offset from decode
//            HOLD                 - downstream stall, freezes the stage
//            IMEM_READ/ADDR/RDATA/BUSYWAIT - instruction memory handshake
//            INSTRUCTION, INSTR_VALID      - registered instruction to decode
//            PC, PC_PLUS4         - current PC and its sequential successor
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              I_W      = 32,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             JUMP,
  input  logic             BRANCH,
  input  logic             ZERO,
  input  logic [OFF_W-1:0] OFFSET,
  input  logic             HOLD,
  output logic             IMEM_READ,
  output logic [PC_W-1:0]  IMEM_ADDR,
  input  logic [I_W-1:0]   IMEM_RDATA,
  input  logic             IMEM_BUSYWAIT,
  output logic [I_W-1:0]   INSTRUCTION,
  output logic             INSTR_VALID,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PC_PLUS4
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [I_W-1:0]  r_instr;
  logic [I_W-1:0]  w_instr_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_read;
  logic            w_read_nxt;

  logic            w_take;
  logic [PC_W-1:0] w_off_ext;
  logic [PC_W-1:0] w_next_pc;

  // Next-PC arithmetic; everything wraps modulo 2^PC_W by construction.
  assign PC_PLUS4  = r_pc + PC_W'(4);
  assign w_take    = JUMP | (BRANCH & ZERO);
  assign w_off_ext = {{(PC_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
  assign w_next_pc = PC_PLUS4 + (w_take ? (w_off_ext << 2) : {PC_W{1'b0}});

  // State and registered outputs. Reset dominates everything, so a read in
  // flight is abandoned and its data never captured.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= {I_W{1'b0}};
      r_valid <= 1'b0;
      r_read  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_read  <= w_read_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   if (!IMEM_BUSYWAIT) w_state_nxt = S_EXEC;
      S_EXEC:  if (!HOLD) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs. Control-flow inputs only matter
  // on the EXEC edge that releases the instruction.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_read_nxt  = r_read;
    case (r_state)
      S_IDLE: begin
        w_read_nxt  = 1'b1;
        w_valid_nxt = 1'b0;
      end
      S_REQ: begin
        w_read_nxt  = 1'b1;
        w_valid_nxt = 1'b0;
        if (!IMEM_BUSYWAIT) begin
          w_instr_nxt = IMEM_RDATA;
          w_valid_nxt = 1'b1;
          w_read_nxt  = 1'b0;
        end
      end
      S_EXEC: begin
        w_read_nxt  = 1'b0;
        w_valid_nxt = 1'b1;
        if (!HOLD) begin
          w_pc_nxt    = w_next_pc;
          w_valid_nxt = 1'b0;
          w_read_nxt  = 1'b1;
        end
      end
      default: begin
        w_read_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign IMEM_READ   = r_read;
  assign IMEM_ADDR   = r_pc;
  assign PC          = r_pc;
  assign INSTRUCTION = r_instr;
  assign INSTR_VALID = r_valid;

endmodule
`default_nettype wire
